fpga_status_display: RTL and testbench
======================================

Name: fpga_status_display

Overview:
- Parametrised exit-status and heartbeat display for the FPGA SoC top.
- Sits between the SoC exit word and the board LEDs, and replaces the fixed "low 8 bits on LEDs" mapping.
- Shows a walking heartbeat while the program runs.
- On the exit condition it latches the exit code once, then either blinks all LEDs (pass) or pages through the code NrLeds bits at a time (fail).
- Supports a manual hold/page-select for debug via switches or VIO.

Parameters:
- ExitWidth, 64: width of the exit word. Bit 0 is the done flag; bits [ExitWidth-1:1] are the exit code. Must be >= 2.
- NrLeds, 8: number of LEDs driven. Must be >= 1.
- DwellCycles, 50_000_000: clock cycles per heartbeat step and per display page. Must be >= 1.
- BlinkCycles, 25_000_000: clock cycles per blink half-period in pass state. Must be >= 1.
- Derived localparam NumPages = ceil((ExitWidth-1)/NrLeds).
- Derived localparam PageIdxW = max(1, $clog2(NumPages)).

Ports:
- clk_i  in  1  block clock, same domain as the SoC.
- rst_i  in  1  reset.
- exit_i  in  ExitWidth  SoC exit word.
- page_hold_i  in  1  1 = freeze auto-paging and use page_sel_i.
- page_sel_i  in  PageIdxW  manual page index, used only when page_hold_i = 1.
- leds_o  out  NrLeds  LED drive, active-high.
- state_o  out  2  current display state.
- exit_code_o  out  ExitWidth-1  latched exit code.
- page_o  out  PageIdxW  page currently shown.

Interface decisions:
- One clock; reset is synchronous and active-high.

Behaviour:
- Reset values (rst_i high at an edge): leds_o = 0, state_o = StRunning, exit_code_o = 0, page_o = 0, all counters = 0. Reset has priority over every other event.
- Input stage: exit_i is registered once. If exit_i[0] is sampled high at edge k:
  - state_o and exit_code_o update at edge k+1.
  - leds_o reflects the new state from edge k+2.
  - All outputs are registered.
- Tick generators: the dwell tick pulses for one cycle each time its counter reaches DwellCycles-1, then the counter wraps to 0. The blink tick does the same with BlinkCycles. Both counters clear on every state entry, so the first step or page always lasts a full period.
- StRunning:
  - leds_o is a walking one, starting at LED0 one cycle after reset release.
  - It advances one position per dwell tick and wraps from LED NrLeds-1 to LED0.
  - If NrLeds = 1, the LED toggles on each tick instead.
- Exit detection (StRunning only): the registered exit_i[0] = 1 latches exit_code_o = exit_i[ExitWidth-1:1].
  - Code == 0: go to StPass.
  - Code != 0: go to StFail.
- Latch-once: in StPass and StFail, exit_i is ignored until reset. Detection is level-sensitive, so if exit_i[0] is still 1 after reset release, the code is re-latched.
- StPass: all LEDs on, then inverted on each blink tick, giving all-on/all-off alternation. page_o = 0.
- StFail:
  - Page p shows exit_code_o[p*NrLeds +: NrLeds]. Bits beyond ExitWidth-2 read as 0.
  - Entry page is 0. The page increments on each dwell tick and wraps from NumPages-1 to 0.
  - page_hold_i = 1: auto-paging stops and page = min(page_sel_i, NumPages-1). The change is visible on leds_o one cycle after it is sampled.
  - On release of page_hold_i, auto-paging resumes from the held page with the dwell counter cleared.
- page_hold_i has no effect in StRunning or StPass.
- No illegal state is reachable. The default branch returns to StRunning.

Decomposition:
- fpga_status_pkg:
  - typedef enum logic [1:0] status_state_e: StRunning = 2'd0, StPass = 2'd1, StFail = 2'd2.
  - A function computing NumPages.
- Sub-module fpga_status_tick_gen:
  - Parameters: Cycles.
  - Ports: clk_i, rst_i, clr_i, tick_o.
  - Instantiated twice, once for dwell and once for blink.
- Everything else (FSM, latch, page counter, LED mux) lives in fpga_status_display.

Test Plan (ExitWidth=16, NrLeds=4, DwellCycles=4, BlinkCycles=2, NumPages=4):
- Reset check: hold rst_i for 3 cycles, then release with exit_i = 0 -> all outputs 0 during reset. leds_o goes 4'b0001, then 4'b0010 after 4 cycles, 4'b0100, 4'b1000, and back to 4'b0001 after 16 cycles. state_o stays 0.
- Pass: exit_i = 16'h0001 -> state_o = 1 and exit_code_o = 0 two edges after it is applied. leds_o alternates 4'b1111 / 4'b0000 every 2 cycles.
- Fail paging: exit_i = 16'h2469 -> exit_code_o = 15'h1234 and state_o = 2. leds_o shows 4'h4, 4'h3, 4'h2, 4'h1 for 4 cycles each, then wraps to 4'h4. page_o counts 0..3.
- Latch-once: in StFail, change exit_i to 16'h0001 and then 16'hFFFF -> state_o stays 2, exit_code_o stays 15'h1234, paging is unaffected.
- Manual hold: page_hold_i = 1 with page_sel_i = 2 -> leds_o = 4'h2 constant for 20 cycles. With page_sel_i = 3, leds_o = 4'h1. After release, the next page 0 appears 4 cycles later.
- Reset mid-fail: assert rst_i for 1 cycle in StFail with exit_i held at 16'h2469 -> leds_o = 0 and state_o = 0 after the reset edge, then the code is re-latched and state_o returns to 2 two edges after release.

Source files
------------

// File: rtl/fpga_status_pkg.sv
// ============================================================================
// Module      : fpga_status_pkg
// Description : Shared state encoding and page-count helpers for the status display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpga_status_pkg;

    typedef enum logic [1:0] {
        StRunning = 2'd0,
        StPass    = 2'd1,
        StFail    = 2'd2
    } status_state_e;

    // The done flag occupies bit 0, so only ExitWidth-1 code bits are paged.
    function automatic int num_pages(input int exit_width, input int nr_leds);
        return (exit_width - 1 + nr_leds - 1) / nr_leds;
    endfunction

    function automatic int page_idx_w(input int exit_width, input int nr_leds);
        int n;
        n = num_pages(exit_width, nr_leds);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpga_status_tick_gen.sv
// ============================================================================
// Module      : fpga_status_tick_gen
// Description : Free-running period counter emitting a one-cycle tick every Cycles clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpga_status_tick_gen #(
    parameter int Cycles = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int                c_cnt_w    = (Cycles > 1) ? $clog2(Cycles) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(Cycles - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;
    logic               at_last;

    always_comb begin
        at_last = (cnt_q == c_last_cnt);
        cnt_d   = cnt_q + c_cnt_w'(1);
        if (clr_i || at_last) begin
            cnt_d = '0;
        end
    end

    // A clear wins over a coincident terminal count so a restarted period is never cut short.
    assign tick_o = at_last && !clr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpga_status_display.sv
// ============================================================================
// Module      : fpga_status_display
// Description : Heartbeat while running, then pass blink or paged fail code on the LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpga_status_display
    import fpga_status_pkg::*;
#(
    parameter  int ExitWidth   = 64,
    parameter  int NrLeds      = 8,
    parameter  int DwellCycles = 50_000_000,
    parameter  int BlinkCycles = 25_000_000,
    localparam int NumPages    = num_pages(ExitWidth, NrLeds),
    localparam int PageIdxW    = page_idx_w(ExitWidth, NrLeds)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ExitWidth-1:0] exit_i,
    input  logic                 page_hold_i,
    input  logic [PageIdxW-1:0]  page_sel_i,
    output logic [NrLeds-1:0]    leds_o,
    output logic [1:0]           state_o,
    output logic [ExitWidth-2:0] exit_code_o,
    output logic [PageIdxW-1:0]  page_o
);

    localparam int                 c_pad_w     = NumPages * NrLeds;
    localparam logic [PageIdxW-1:0] c_last_page = PageIdxW'(NumPages - 1);

    logic [ExitWidth-1:0] exit_q;
    status_state_e        state_q,   state_d;
    logic [ExitWidth-2:0] code_q,    code_d;
    logic [NrLeds-1:0]    leds_q,    leds_d;
    logic [NrLeds-1:0]    walk_q,    walk_d;
    logic [NrLeds-1:0]    walk_next;
    logic                 blink_off_q, blink_off_d;
    logic [PageIdxW-1:0]  page_q,    page_d;
    logic [PageIdxW-1:0]  shown_q,   shown_d;
    logic [PageIdxW-1:0]  page_sel_clamped;
    logic [c_pad_w-1:0]   code_pad;
    logic                 entry;
    logic                 dwell_clr;
    logic                 dwell_tick;
    logic                 blink_tick;

    fpga_status_tick_gen #(
        .Cycles (DwellCycles)
    ) u_dwell_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (dwell_clr),
        .tick_o (dwell_tick)
    );

    fpga_status_tick_gen #(
        .Cycles (BlinkCycles)
    ) u_blink_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (entry),
        .tick_o (blink_tick)
    );

    if (NrLeds == 1) begin : g_walk_toggle
        assign walk_next = ~walk_q;
    end else begin : g_walk_rotate
        assign walk_next = {walk_q[NrLeds-2:0], walk_q[NrLeds-1]};
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            StRunning: begin
                if (exit_q[0]) begin
                    code_d  = exit_q[ExitWidth-1:1];
                    state_d = (|exit_q[ExitWidth-1:1]) ? StFail : StPass;
                end
            end
            StPass, StFail: begin
                state_d = state_q;
            end
            default: begin
                state_d = StRunning;
            end
        endcase
    end

    // Holding a page keeps the dwell counter cleared so a release restarts a full period.
    assign entry            = (state_d != state_q);
    assign dwell_clr        = entry || ((state_q == StFail) && page_hold_i);
    assign page_sel_clamped = (page_sel_i > c_last_page) ? c_last_page : page_sel_i;
    assign code_pad         = c_pad_w'(code_q);

    always_comb begin
        walk_d      = walk_q;
        blink_off_d = blink_off_q;
        page_d      = page_q;
        if (entry) begin
            blink_off_d = 1'b0;
            page_d      = '0;
        end else begin
            case (state_q)
                StRunning: if (dwell_tick) walk_d = walk_next;
                StPass:    if (blink_tick) blink_off_d = ~blink_off_q;
                StFail: begin
                    if (page_hold_i) begin
                        page_d = page_sel_clamped;
                    end else if (dwell_tick) begin
                        page_d = (page_q == c_last_page) ? '0 : page_q + PageIdxW'(1);
                    end
                end
                default: begin
                    page_d = '0;
                end
            endcase
        end
    end

    // LEDs follow the registered state, so they lag a state change by one cycle.
    always_comb begin
        leds_d  = '0;
        shown_d = '0;
        case (state_q)
            StRunning: leds_d = walk_q;
            StPass:    leds_d = blink_off_q ? '0 : '1;
            StFail: begin
                leds_d  = code_pad[int'(page_q) * NrLeds +: NrLeds];
                shown_d = page_q;
            end
            default: leds_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exit_q      <= '0;
            state_q     <= StRunning;
            code_q      <= '0;
            leds_q      <= '0;
            walk_q      <= NrLeds'(1);
            blink_off_q <= 1'b0;
            page_q      <= '0;
            shown_q     <= '0;
        end else begin
            exit_q      <= exit_i;
            state_q     <= state_d;
            code_q      <= code_d;
            leds_q      <= leds_d;
            walk_q      <= walk_d;
            blink_off_q <= blink_off_d;
            page_q      <= page_d;
            shown_q     <= shown_d;
        end
    end

    assign leds_o      = leds_q;
    assign state_o     = state_q;
    assign exit_code_o = code_q;
    assign page_o      = shown_q;

endmodule

`default_nettype wire

// File: tb/tb_fpga_status_display.sv
// ============================================================================
// Module      : tb_fpga_status_display
// Description : Directed-vector bench for fpga_status_display (16-bit exit, 4 LEDs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpga_status_display;

    logic        clk;
    logic        rst;
    logic [15:0] exit_w;
    logic        page_hold;
    logic [1:0]  page_sel;
    logic [3:0]  leds;
    logic [1:0]  state;
    logic [14:0] exit_code;
    logic [1:0]  page;

    int n_vec = 0;
    int n_err = 0;

    fpga_status_display #(
        .ExitWidth   (16),
        .NrLeds      (4),
        .DwellCycles (4),
        .BlinkCycles (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .exit_i      (exit_w),
        .page_hold_i (page_hold),
        .page_sel_i  (page_sel),
        .leds_o      (leds),
        .state_o     (state),
        .exit_code_o (exit_code),
        .page_o      (page)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Code 0x1234 paged four bits at a time, low nibble first.
    function automatic logic [3:0] fail_nibble(input int p);
        case (p)
            0:       return 4'h4;
            1:       return 4'h3;
            2:       return 4'h2;
            default: return 4'h1;
        endcase
    endfunction

    initial begin
        logic [3:0] exp_leds;
        int         p;

        rst       = 1'b1;
        exit_w    = 16'h0000;
        page_hold = 1'b0;
        page_sel  = 2'd0;

        repeat (3) @(negedge clk);
        check_value("rst_leds",  32'(leds),      32'h0);
        check_value("rst_state", 32'(state),     32'h0);
        check_value("rst_code",  32'(exit_code), 32'h0);
        check_value("rst_page",  32'(page),      32'h0);

        rst = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            exp_leds = 4'b0001 << (((i - 1) / 4) % 4);
            check_value("run_leds",  32'(leds),  32'(exp_leds));
            check_value("run_state", 32'(state), 32'h0);
        end

        exit_w = 16'h0001;
        @(negedge clk);
        check_value("pass_state_early", 32'(state), 32'h0);
        @(negedge clk);
        check_value("pass_state", 32'(state),     32'h1);
        check_value("pass_code",  32'(exit_code), 32'h0);
        for (int j = 2; j <= 9; j++) begin
            @(negedge clk);
            check_value("pass_leds", 32'(leds), ((((j - 2) / 2) % 2) == 0) ? 32'hF : 32'h0);
            check_value("pass_page", 32'(page), 32'h0);
        end

        rst    = 1'b1;
        exit_w = 16'h0000;
        @(negedge clk);
        check_value("rst2_state", 32'(state), 32'h0);
        check_value("rst2_leds",  32'(leds),  32'h0);

        rst    = 1'b0;
        exit_w = 16'h2469;
        @(negedge clk);
        check_value("fail_state_early", 32'(state), 32'h0);
        @(negedge clk);
        check_value("fail_state", 32'(state),     32'h2);
        check_value("fail_code",  32'(exit_code), 32'h1234);
        for (int j = 2; j <= 33; j++) begin
            if (j == 18) exit_w = 16'h0001;
            if (j == 24) exit_w = 16'hFFFF;
            @(negedge clk);
            p = ((j - 2) / 4) % 4;
            check_value("fail_leds",  32'(leds),      32'(fail_nibble(p)));
            check_value("fail_page",  32'(page),      32'(p));
            check_value("latch_state", 32'(state),    32'h2);
            check_value("latch_code", 32'(exit_code), 32'h1234);
        end

        page_hold = 1'b1;
        page_sel  = 2'd2;
        @(negedge clk);
        check_value("hold_lag", 32'(leds), 32'h4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_value("hold2_leds", 32'(leds), 32'h2);
            check_value("hold2_page", 32'(page), 32'h2);
        end

        page_sel = 2'd3;
        @(negedge clk);
        check_value("hold3_lag", 32'(leds), 32'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("hold3_leds", 32'(leds), 32'h1);
            check_value("hold3_page", 32'(page), 32'h3);
        end

        page_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_value("release_leds", 32'(leds), 32'h1);
        end
        @(negedge clk);
        check_value("release_wrap_leds", 32'(leds), 32'h4);
        check_value("release_wrap_page", 32'(page), 32'h0);

        exit_w = 16'h2469;
        rst    = 1'b1;
        @(negedge clk);
        check_value("midrst_leds",  32'(leds),      32'h0);
        check_value("midrst_state", 32'(state),     32'h0);
        check_value("midrst_code",  32'(exit_code), 32'h0);
        check_value("midrst_page",  32'(page),      32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_value("relatch_state_early", 32'(state), 32'h0);
        check_value("relatch_walk",        32'(leds),  32'h1);
        @(negedge clk);
        check_value("relatch_state", 32'(state),     32'h2);
        check_value("relatch_code",  32'(exit_code), 32'h1234);
        check_value("relatch_leds0", 32'(leds),      32'h1);
        @(negedge clk);
        check_value("relatch_leds", 32'(leds), 32'h4);
        check_value("relatch_page", 32'(page), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
